proj_counter: RTL and testbench



---
 rtl/proj_pkg.sv | 9 +
 rtl/proj_counter.sv | 48 ++++
 tb/tb_proj_counter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/proj_pkg.sv
// Shared definitions for the feature-map (FM) buffer: slot count and slot index type.
package proj_pkg;

  localparam int FM_BUFFER_SIZE = 8;

  // Slot index is as wide as the slot count; only the low bits ever carry a value.
  typedef logic [FM_BUFFER_SIZE-1:0] fm_index_t;

endpackage : proj_pkg

// File: rtl/proj_counter.sv
// Free-running modulo-SIZE slot index counter for FM buffer addressing, with a terminal-slot flag.
// Optional embedded assertions are compiled in when PROJ_COUNTER_ASSERT_EN is defined.
module proj_counter
  import proj_pkg::*;
#(
  parameter int SIZE = FM_BUFFER_SIZE
) (
  input  logic            in_clk,
  input  logic            in_rst_n,
  output logic [SIZE-1:0] index,
  output logic            finished_count
);

  // Full-width constants, so the compare and the increment never truncate.
  localparam logic [SIZE-1:0] LAST = SIZE'(SIZE - 1);
  localparam logic [SIZE-1:0] ONE  = SIZE'(1);

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      index <= '0;
    end else if (index == LAST) begin
      index <= '0;
    end else begin
      index <= index + ONE;
    end
  end

  // Terminal slot decoded from the registered index; low during reset because index is 0.
  assign finished_count = (index == LAST);

`ifdef PROJ_COUNTER_ASSERT_EN
  a_index_range : assert property (@(posedge in_clk) disable iff (!in_rst_n)
    index <= LAST);

  a_index_step : assert property (@(posedge in_clk) disable iff (!in_rst_n)
    $past(in_rst_n) |->
      index == (($past(index) == LAST) ? '0 : $past(index) + ONE));

  a_finished_decode : assert property (@(posedge in_clk) disable iff (!in_rst_n)
    finished_count == (index == LAST));

  // Checked on the falling edge so an asynchronous reset has already taken effect.
  a_reset_zero : assert property (@(negedge in_clk)
    !in_rst_n |-> index == '0);
`else
`endif

endmodule : proj_counter

// File: tb/tb_proj_counter.sv
// Directed, table-driven bench for proj_counter: reset, counting, wrap, terminal flag, mid-count reset.
module tb_proj_counter;

  localparam int SIZE   = proj_pkg::FM_BUFFER_SIZE;
  localparam int NVEC   = 2 * SIZE;
  localparam int MID    = SIZE / 2 + 1;

  typedef struct {
    logic [SIZE-1:0] exp_index;
    logic            exp_fin;
  } vec_t;

  logic            in_clk;
  logic            in_rst_n;
  logic [SIZE-1:0] index;
  logic            finished_count;

  int checks;
  int failures;

  vec_t vec [NVEC];

  proj_counter #(.SIZE(SIZE)) dut (
    .in_clk         (in_clk),
    .in_rst_n       (in_rst_n),
    .index          (index),
    .finished_count (finished_count)
  );

  // Clock: period 10, rising edges at 5, 15, 25, ...
  initial begin
    in_clk = 1'b0;
    forever #5 in_clk = ~in_clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check_index(input string name, input logic [SIZE-1:0] exp);
    checks++;
    if (index !== exp) begin
      failures++;
      $display("FAIL %s: index=%0h expected=%0h at %0t", name, index, exp, $time);
    end
  endtask

  task automatic check_fin(input string name, input logic exp);
    checks++;
    if (finished_count !== exp) begin
      failures++;
      $display("FAIL %s: finished_count=%0b expected=%0b at %0t", name, finished_count, exp, $time);
    end
  endtask

  // Applies the whole vector table, one rising edge per record, sampling 1 ns after the edge.
  task automatic run_table(input string name);
    for (int i = 0; i < NVEC; i++) begin
      @(posedge in_clk);
      #1;
      check_index({name, "_index"}, vec[i].exp_index);
      check_fin({name, "_fin"}, vec[i].exp_fin);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Record k is the state after k+1 edges from reset release.
    for (int k = 0; k < NVEC; k++) begin
      vec[k].exp_index = SIZE'((k + 1) % SIZE);
      vec[k].exp_fin   = (((k + 1) % SIZE) == SIZE - 1);
    end

    // Scenario 1: reset asserted away from any edge, held two cycles, released between edges.
    in_rst_n = 1'b1;
    #2;
    in_rst_n = 1'b0;
    #1;
    check_index("async_reset_index", '0);
    check_fin("async_reset_fin", 1'b0);
    repeat (2) @(posedge in_clk);
    #1;
    check_index("reset_held_index", '0);
    check_fin("reset_held_fin", 1'b0);
    @(negedge in_clk);
    in_rst_n = 1'b1;
    #1;
    check_index("release_no_edge_index", '0);
    check_fin("release_no_edge_fin", 1'b0);

    // Scenarios 2-3: two full passes with wrap and the terminal flag.
    run_table("pass1");

    // Scenario 4: count to a mid value, then reset asynchronously at a falling edge.
    repeat (MID) @(posedge in_clk);
    #1;
    check_index("mid_count_index", SIZE'(MID % SIZE));
    @(negedge in_clk);
    in_rst_n = 1'b0;
    #1;
    check_index("mid_reset_index", '0);
    check_fin("mid_reset_fin", 1'b0);
    for (int c = 0; c < 2; c++) begin
      @(posedge in_clk);
      #1;
      check_index("mid_reset_hold_index", '0);
      check_fin("mid_reset_hold_fin", 1'b0);
    end

    // Scenario 5: release at a falling edge; sequence restarts exactly as after the first reset.
    @(negedge in_clk);
    in_rst_n = 1'b1;
    #1;
    check_index("rerelease_index", '0);
    run_table("pass2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_proj_counter
